// File: rtl/dpmu_pkg.sv
// Shared power-management definitions: code widths, reset operating point,
// sequencer state encoding and the phase-selection helper.
package dpmu_pkg;

  localparam int unsigned V_W = 2;
  localparam int unsigned F_W = 3;

  localparam logic [V_W-1:0] V_DEFAULT = 2'b01;
  localparam logic [F_W-1:0] F_DEFAULT = 3'b010;

  typedef enum logic [2:0] {
    IDLE,
    V_UP,
    F_STEP,
    V_DOWN,
    SETTLE
  } dvfs_state_t;

  // Picks the phase that owns the next step. Voltage rises before frequency
  // moves and falls after it. When nothing is left to change, F_STEP is
  // returned and acts as the completion slot.
  function automatic dvfs_state_t next_phase(input logic [V_W-1:0] tv,
                                             input logic [F_W-1:0] tf,
                                             input logic [V_W-1:0] cv,
                                             input logic [F_W-1:0] cf);
    if (tv > cv) return V_UP;
    if (tf != cf) return F_STEP;
    if (tv < cv) return V_DOWN;
    return F_STEP;
  endfunction

endpackage

// File: rtl/dvfs_seq_if.sv
// Operating-point request handshake between a power manager and dvfs_seq.
interface dvfs_seq_if;

  logic                        req_valid;
  logic                        req_ready;
  logic [dpmu_pkg::V_W-1:0]    tgt_v;
  logic [dpmu_pkg::F_W-1:0]    tgt_f;

  modport master (
    output req_valid,
    output tgt_v,
    output tgt_f,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  tgt_v,
    input  tgt_f,
    output req_ready
  );

endinterface

// File: rtl/dvfs_settle_timer.sv
// Settle-time down-counter: load arms it, expire is high during the last
// cycle of the wait so the owner acts on the following edge.
module dvfs_settle_timer #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic clear,
  output logic expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= 8'(SETTLE_CYCLES - 1);
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expire = (cnt == 8'd1);

endmodule

// File: rtl/dvfs_seq.sv
// DVFS sequencer: walks voltage and frequency codes one step at a time to a
// requested operating point, with a settle wait between steps.
module dvfs_seq
  import dpmu_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  dvfs_seq_if.slave       req,
  input  logic            emerg,
  output logic [V_W-1:0]  cur_v,
  output logic [F_W-1:0]  cur_f,
  output logic            busy,
  output logic            done,
  output logic            aborted
);

  dvfs_state_t     state;
  dvfs_state_t     follow;
  logic [V_W-1:0]  lat_v, nv;
  logic [F_W-1:0]  lat_f, nf;
  logic            emerg_q;
  logic            step_now;
  logic            finishing;
  logic            expire;

  // Phase states hold the step that fires on the next edge; F_STEP with the
  // frequency already on target is the completion slot.
  always_comb begin
    nv = cur_v;
    nf = cur_f;
    case (state)
      V_UP:   nv = cur_v + 1'b1;
      V_DOWN: nv = cur_v - 1'b1;
      F_STEP: begin
        if (cur_f < lat_f)      nf = cur_f + 1'b1;
        else if (cur_f > lat_f) nf = cur_f - 1'b1;
      end
      default: ;
    endcase
    follow = next_phase(lat_v, lat_f, nv, nf);
  end

  assign step_now      = state inside {V_UP, F_STEP, V_DOWN};
  assign finishing     = (state == F_STEP) && (cur_f == lat_f);
  assign busy          = (state != IDLE);
  assign req.req_ready = (state == IDLE) && !emerg;

  dvfs_settle_timer #(.SETTLE_CYCLES(SETTLE_CYCLES)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (step_now && !finishing),
    .clear  (emerg),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur_v   <= V_DEFAULT;
      cur_f   <= F_DEFAULT;
      lat_v   <= '0;
      lat_f   <= '0;
      done    <= 1'b0;
      aborted <= 1'b0;
      emerg_q <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      emerg_q <= emerg;
      if (emerg) begin
        cur_f   <= '0;
        state   <= IDLE;
        aborted <= !emerg_q;
      end else begin
        case (state)
          IDLE: begin
            if (req.req_valid) begin
              lat_v <= req.tgt_v;
              lat_f <= req.tgt_f;
              state <= next_phase(req.tgt_v, req.tgt_f, cur_v, cur_f);
            end
          end
          SETTLE: begin
            if (expire) state <= next_phase(lat_v, lat_f, cur_v, cur_f);
          end
          V_UP, F_STEP, V_DOWN: begin
            if (finishing) begin
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              cur_v <= nv;
              cur_f <= nf;
              state <= (SETTLE_CYCLES == 1) ? follow : SETTLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dvfs_seq.sv
// Self-checking bench for dvfs_seq with a short settle time; step/done events
// are predicted into a scoreboard queue and matched as the DUT produces them.
module tb_dvfs_seq;

  localparam int unsigned S = 4;

  typedef struct {
    int unsigned t;
    logic [1:0]  v;
    logic [2:0]  f;
    logic        fin;
  } ev_t;

  logic       clk;
  logic       rst_n;
  logic       emerg;
  logic [1:0] cur_v;
  logic [2:0] cur_f;
  logic       busy;
  logic       done;
  logic       aborted;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [1:0] model_v;
  logic [2:0] model_f;
  ev_t        sbq[$];

  dvfs_seq_if rq ();

  dvfs_seq #(.SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (rq),
    .emerg   (emerg),
    .cur_v   (cur_v),
    .cur_f   (cur_f),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (cur_v !== 2'b01 || cur_f !== 3'b010) begin
      failures++;
      $display("FAIL reset_point got v=%b f=%b exp v=01 f=010", cur_v, cur_f);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags got busy=%b done=%b aborted=%b exp 0 0 0", busy, done, aborted);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rq.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=1", rq.req_ready);
    end
    model_v = 2'b01;
    model_f = 3'b010;
  endtask

  // Predicts the step schedule, issues the request, then matches every
  // output change or done pulse against the next predicted event.
  task automatic test_seq(input string name, input logic [1:0] tv, input logic [2:0] tf);
    int unsigned t;
    int unsigned cyc;
    logic [1:0]  pv;
    logic [2:0]  pf;
    ev_t         e;
    t = 1;
    while (model_v < tv) begin
      model_v = model_v + 2'd1;
      sbq.push_back('{t, model_v, model_f, 1'b0});
      t += S;
    end
    while (model_f != tf) begin
      if (model_f < tf) model_f = model_f + 3'd1;
      else              model_f = model_f - 3'd1;
      sbq.push_back('{t, model_v, model_f, 1'b0});
      t += S;
    end
    while (model_v > tv) begin
      model_v = model_v - 2'd1;
      sbq.push_back('{t, model_v, model_f, 1'b0});
      t += S;
    end
    sbq.push_back('{t, model_v, model_f, 1'b1});

    pv = cur_v;
    pf = cur_f;
    rq.req_valid = 1'b1;
    rq.tgt_v     = tv;
    rq.tgt_f     = tf;
    checks++;
    if (rq.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_ready_at_accept got=%b exp=1", name, rq.req_ready);
    end
    @(posedge clk);
    #1;
    rq.req_valid = 1'b0;
    cyc = 0;
    while (sbq.size() > 0 && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cur_v !== pv || cur_f !== pf || done === 1'b1) begin
        e = sbq.pop_front();
        checks++;
        if (cyc !== e.t || cur_v !== e.v || cur_f !== e.f || done !== e.fin) begin
          failures++;
          $display("FAIL %s_event got t=%0d v=%b f=%b done=%b exp t=%0d v=%b f=%b done=%b",
                   name, cyc, cur_v, cur_f, done, e.t, e.v, e.f, e.fin);
        end
        if (e.fin) begin
          checks++;
          if (rq.req_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_on_done got ready=%b busy=%b exp ready=1 busy=0",
                     name, rq.req_ready, busy);
          end
        end
        pv = cur_v;
        pf = cur_f;
      end
    end
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL %s_timeout got pending=%0d exp pending=0", name, sbq.size());
    end
    sbq.delete();
  endtask

  task automatic test_emerg();
    int unsigned ab_cnt;
    ab_cnt = 0;
    rq.req_valid = 1'b1;
    rq.tgt_v     = 2'b11;
    rq.tgt_f     = 3'b011;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (cur_v !== 2'b01 || cur_f !== 3'b011) begin
      failures++;
      $display("FAIL emerg_first_step got v=%b f=%b exp v=01 f=011", cur_v, cur_f);
    end
    @(posedge clk); #1;
    emerg = 1'b1;
    @(posedge clk); #1;
    if (aborted === 1'b1) ab_cnt++;
    checks++;
    if (cur_f !== 3'b000 || cur_v !== 2'b01 || aborted !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL emerg_edge got v=%b f=%b aborted=%b busy=%b done=%b exp v=01 f=000 aborted=1 busy=0 done=0",
               cur_v, cur_f, aborted, busy, done);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (aborted === 1'b1) ab_cnt++;
      checks++;
      if (cur_f !== 3'b000 || cur_v !== 2'b01 || rq.req_ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL emerg_hold got v=%b f=%b ready=%b busy=%b done=%b exp v=01 f=000 ready=0 busy=0 done=0",
                 cur_v, cur_f, rq.req_ready, busy, done);
      end
    end
    checks++;
    if (ab_cnt != 1) begin
      failures++;
      $display("FAIL emerg_abort_count got=%0d exp=1", ab_cnt);
    end
    rq.req_valid = 1'b0;
    emerg = 1'b0;
    #1;
    checks++;
    if (rq.req_ready !== 1'b1) begin
      failures++;
      $display("FAIL emerg_release_ready got=%b exp=1", rq.req_ready);
    end
    model_v = 2'b01;
    model_f = 3'b000;
  endtask

  task automatic test_reset_mid();
    rq.req_valid = 1'b1;
    rq.tgt_v     = 2'b11;
    rq.tgt_f     = 3'b111;
    @(posedge clk); #1;
    rq.req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_v !== 2'b10 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_first_step got v=%b busy=%b exp v=10 busy=1", cur_v, busy);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cur_v !== 2'b01 || cur_f !== 3'b010 || busy !== 1'b0 || done !== 1'b0 || aborted !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_edge got v=%b f=%b busy=%b done=%b aborted=%b exp v=01 f=010 busy=0 done=0 aborted=0",
               cur_v, cur_f, busy, done, aborted);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++;
      if (cur_v !== 2'b01 || cur_f !== 3'b010 || busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_after got v=%b f=%b busy=%b done=%b exp v=01 f=010 busy=0 done=0",
                 cur_v, cur_f, busy, done);
      end
    end
    model_v = 2'b01;
    model_f = 3'b010;
  endtask

  task automatic test_back_to_back();
    int unsigned exp_acc[$];
    int unsigned exp_done[$];
    int unsigned e;
    // One f step (done at 1+S), then the held request re-accepts on the
    // done cycle as a zero-step sequence.
    exp_acc.push_back(0);
    exp_acc.push_back(S + 2);
    exp_done.push_back(S + 1);
    exp_done.push_back(S + 3);
    rq.req_valid = 1'b1;
    rq.tgt_v     = 2'b01;
    rq.tgt_f     = 3'b011;
    for (int c = 0; c <= int'(S) + 4; c++) begin
      if (rq.req_valid === 1'b1 && rq.req_ready === 1'b1) begin
        e = (exp_acc.size() > 0) ? exp_acc.pop_front() : 999;
        checks++;
        if (c !== int'(e)) begin
          failures++;
          $display("FAIL b2b_accept got edge=%0d exp edge=%0d", c, e);
        end
      end
      @(posedge clk); #1;
      if (done === 1'b1) begin
        e = (exp_done.size() > 0) ? exp_done.pop_front() : 999;
        checks++;
        if (c !== int'(e)) begin
          failures++;
          $display("FAIL b2b_done got edge=%0d exp edge=%0d", c, e);
        end
      end
      if (c == int'(S) + 2) rq.req_valid = 1'b0;
    end
    checks++;
    if (exp_acc.size() != 0 || exp_done.size() != 0) begin
      failures++;
      $display("FAIL b2b_missing got pending_acc=%0d pending_done=%0d exp 0 0",
               exp_acc.size(), exp_done.size());
    end
    checks++;
    if (cur_v !== 2'b01 || cur_f !== 3'b011) begin
      failures++;
      $display("FAIL b2b_final got v=%b f=%b exp v=01 f=011", cur_v, cur_f);
    end
    model_v = 2'b01;
    model_f = 3'b011;
  endtask

  initial begin
    rst_n        = 1'b0;
    emerg        = 1'b0;
    rq.req_valid = 1'b0;
    rq.tgt_v     = '0;
    rq.tgt_f     = '0;
    model_v      = 2'b01;
    model_f      = 3'b010;
    test_reset();
    test_seq("up_max", 2'b11, 3'b111);
    test_seq("down_min", 2'b00, 3'b000);
    test_seq("same_point", 2'b00, 3'b000);
    test_seq("f_only", 2'b00, 3'b011);
    test_emerg();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
